// File: rtl/spi_slave_serial.sv
// rtl/spi_slave_serial.sv - serial SPI slave, all CPOL/CPHA modes, pins oversampled in i_clk domain
//
// Ports:
//   i_clk, i_rst          system clock; synchronous active-low reset
//   i_sclk, i_cs, i_mosi  asynchronous SPI pins from the master (CS active-high)
//   o_miso, o_miso_oe     slave data out and pad output enable
//   i_mode                {CPOL,CPHA}, latched when a frame starts
//   i_tx_data/i_tx_valid/o_tx_ready   one-word TX holding register handshake
//   o_rx_data/o_rx_valid  last received word, 1-cycle valid pulse (no backpressure)
//   o_tx_underrun         1-cycle pulse when TX_IDLE is loaded because the holding register was empty
//   o_busy                frame in progress (SHIFT state)
module spi_slave_serial #(
    parameter int                 NB_BITS   = 8,
    parameter bit                 LSB_FIRST = 1'b0,
    parameter logic [NB_BITS-1:0] TX_IDLE   = {NB_BITS{1'b1}}
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_sclk,
    input  logic               i_cs,
    input  logic               i_mosi,
    output logic               o_miso,
    output logic               o_miso_oe,
    input  logic [1:0]         i_mode,
    input  logic [NB_BITS-1:0] i_tx_data,
    input  logic               i_tx_valid,
    output logic               o_tx_ready,
    output logic [NB_BITS-1:0] o_rx_data,
    output logic               o_rx_valid,
    output logic               o_tx_underrun,
    output logic               o_busy
);

    localparam int CW = $clog2(NB_BITS);
    localparam logic [CW-1:0] LAST_BIT = CW'(NB_BITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t state, state_n;

    // Pin synchronizers are left out of reset so a reset with CS held high
    // does not look like a fresh CS rising edge afterwards.
    logic [1:0] sclk_sync, cs_sync, mosi_sync;
    logic       sclk_d, cs_d;

    logic               cpol, cpha;
    logic [NB_BITS-1:0] hold_data, shift_reg, rx_shift, rx_next, shifted;
    logic               hold_valid;
    logic [CW-1:0]      bit_cnt;
    logic               first_skip;   // CPHA=1: next shift edge only exposes the freshly loaded bit
    logic               reload_pend;  // CPHA=0: word done, reload on the coming shift edge

    logic sclk_s, cs_s, mosi_s, sclk_rise, sclk_fall, cs_rise;
    logic leading, trailing, sample_act, shift_act, reload, tx_capture;

    always_ff @(posedge i_clk) begin
        sclk_sync <= {sclk_sync[0], i_sclk};
        cs_sync   <= {cs_sync[0], i_cs};
        mosi_sync <= {mosi_sync[0], i_mosi};
        sclk_d    <= sclk_sync[1];
        cs_d      <= cs_sync[1];
    end

    assign sclk_s    = sclk_sync[1];
    assign cs_s      = cs_sync[1];
    assign mosi_s    = mosi_sync[1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign leading   = cpol ? sclk_fall : sclk_rise;
    assign trailing  = cpol ? sclk_rise : sclk_fall;

    assign tx_capture = i_tx_valid & ~hold_valid;
    assign o_tx_ready = ~hold_valid;

    assign rx_next = LSB_FIRST ? {mosi_s, rx_shift[NB_BITS-1:1]}
                               : {rx_shift[NB_BITS-2:0], mosi_s};
    assign shifted = LSB_FIRST ? {1'b0, shift_reg[NB_BITS-1:1]}
                               : {shift_reg[NB_BITS-2:0], 1'b0};

    always_comb begin
        state_n    = state;
        sample_act = 1'b0;
        shift_act  = 1'b0;
        reload     = 1'b0;
        o_miso     = 1'b0;
        o_miso_oe  = 1'b0;
        o_busy     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (cs_rise) state_n = ST_LOAD;
            end
            ST_LOAD: begin
                reload  = 1'b1;
                state_n = cs_s ? ST_SHIFT : ST_IDLE;
            end
            ST_SHIFT: begin
                o_busy     = 1'b1;
                o_miso_oe  = 1'b1;
                o_miso     = LSB_FIRST ? shift_reg[0] : shift_reg[NB_BITS-1];
                sample_act = cs_s & (cpha ? trailing : leading);
                shift_act  = cs_s & (cpha ? leading : trailing);
                reload     = cpha ? (sample_act && bit_cnt == LAST_BIT)
                                  : (shift_act && reload_pend);
                if (!cs_s) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= ST_IDLE;
            cpol          <= 1'b0;
            cpha          <= 1'b0;
            hold_data     <= '0;
            hold_valid    <= 1'b0;
            shift_reg     <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            first_skip    <= 1'b0;
            reload_pend   <= 1'b0;
            o_rx_data     <= '0;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;
        end else begin
            state         <= state_n;
            o_rx_valid    <= 1'b0;
            o_tx_underrun <= 1'b0;

            if (tx_capture) begin
                hold_data  <= i_tx_data;
                hold_valid <= 1'b1;
            end else if (reload) begin
                hold_valid <= 1'b0;
            end

            if (reload) begin
                shift_reg     <= hold_valid ? hold_data : TX_IDLE;
                o_tx_underrun <= ~hold_valid;
                first_skip    <= cpha;
                reload_pend   <= 1'b0;
            end else if (shift_act) begin
                if (first_skip) first_skip <= 1'b0;
                else            shift_reg  <= shifted;
            end

            case (state)
                ST_IDLE: begin
                    bit_cnt     <= '0;
                    reload_pend <= 1'b0;
                    if (cs_rise) {cpol, cpha} <= i_mode;
                end
                ST_LOAD: begin
                    bit_cnt  <= '0;
                    rx_shift <= '0;
                end
                ST_SHIFT: begin
                    if (sample_act) begin
                        rx_shift <= rx_next;
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt    <= '0;
                            o_rx_data  <= rx_next;
                            o_rx_valid <= 1'b1;
                            if (!cpha) reload_pend <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
